// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, drives the ROM address,
// and captures the returned word into the IF/ID pipeline register. Handles
// stalls, branch/jump redirects with a one-bubble flush, debug step gating,
// and parks the front end once the HALT word has been fetched.
module instruction_fetch #(
  parameter int                     ADDR_LENGTH = 32,
  parameter int                     DATA_LENGTH = 32,
  parameter logic [DATA_LENGTH-1:0] HALT_INSTR  = 32'hFFFF_FFFF,
  parameter logic [DATA_LENGTH-1:0] NOP_INSTR   = 32'h0000_0000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_Enable,
  input  logic                   i_Stall,
  input  logic                   i_Jump,
  input  logic [ADDR_LENGTH-1:0] i_JumpAddr,
  input  logic                   i_Branch,
  input  logic [ADDR_LENGTH-1:0] i_BranchAddr,
  input  logic [DATA_LENGTH-1:0] i_Instr,
  output logic [ADDR_LENGTH-1:0] o_Addr,
  output logic [DATA_LENGTH-1:0] o_Instr,
  output logic [ADDR_LENGTH-1:0] o_PCNext,
  output logic                   o_Valid,
  output logic                   o_Halted
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  fetch_state_e           state;
  logic [ADDR_LENGTH-1:0] pc;
  logic [ADDR_LENGTH-1:0] pc_plus_one;

  // Sequential successor address; wraps naturally modulo 2^ADDR_LENGTH.
  assign pc_plus_one = pc + ADDR_LENGTH'(1);

  // PC, IF/ID register and run/halt state, updated in priority order.
  // NOTE: all state here is written with non-blocking assignments so every
  // register samples the pre-edge values of pc and state, regardless of the
  // order the branches below are written in.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= ST_RUN;
      pc       <= '0;
      o_Instr  <= NOP_INSTR;
      o_PCNext <= '0;
      o_Valid  <= 1'b0;
    end else if (i_Enable && !i_Stall) begin
      if (state == ST_HALTED) begin
        // Parked on the HALT word: keep feeding bubbles, ignore redirects.
        o_Instr  <= NOP_INSTR;
        o_PCNext <= '0;
        o_Valid  <= 1'b0;
      end else if (i_Jump) begin
        pc       <= i_JumpAddr;
        o_Instr  <= NOP_INSTR;
        o_PCNext <= '0;
        o_Valid  <= 1'b0;
      end else if (i_Branch) begin
        pc       <= i_BranchAddr;
        o_Instr  <= NOP_INSTR;
        o_PCNext <= '0;
        o_Valid  <= 1'b0;
      end else begin
        o_Instr  <= i_Instr;
        o_PCNext <= pc_plus_one;
        o_Valid  <= 1'b1;
        // The HALT word is presented once; PC stays pointing at it.
        if (i_Instr == HALT_INSTR) begin
          state <= ST_HALTED;
        end else begin
          pc <= pc_plus_one;
        end
      end
    end
  end

  assign o_Addr   = pc;
  assign o_Halted = (state == ST_HALTED);

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the pipelined processor. It owns the program counter, drives the address input of the combinational `instruction_memory` ROM, and captures the returned word into the IF/ID pipeline register. It applies hazard-unit stalls, branch/jump redirects from ID (with flush), debug-unit enable gating, and halts the pipeline front end when it fetches the HALT word.

## Interface

**Parameters**
- `ADDR_LENGTH`, 32: PC and ROM address width. Addresses are word indices, not byte addresses.
- `DATA_LENGTH`, 32: instruction width.
- `HALT_INSTR`, 32'hFFFFFFFF: encoding of the HALT instruction.
- `NOP_INSTR`, 32'h00000000: word loaded into IF/ID on a flush or bubble.

**Ports** (clock and reset first)
- `i_clk`, input, 1: clock. All state updates on the rising edge.
- `i_rst_n`, input, 1: reset, synchronous and active-low.
- `i_Enable`, input, 1: debug-unit step enable. 0 freezes all state.
- `i_Stall`, input, 1: hazard-unit stall. Holds the PC and IF/ID.
- `i_Jump`, input, 1: jump redirect from ID.
- `i_JumpAddr`, input, ADDR_LENGTH: jump target (word address).
- `i_Branch`, input, 1: taken-branch redirect from ID.
- `i_BranchAddr`, input, ADDR_LENGTH: branch target (word address).
- `i_Instr`, input, DATA_LENGTH: ROM `o_Data`.
- `o_Addr`, output, ADDR_LENGTH: current PC, wired to ROM `i_Addr`.
- `o_Instr`, output, DATA_LENGTH: IF/ID instruction.
- `o_PCNext`, output, ADDR_LENGTH: IF/ID copy of fetched PC+1.
- `o_Valid`, output, 1: IF/ID holds a real instruction.
- `o_Halted`, output, 1: front end is in the HALTED state.

## Operation

**State machine:** two states, RUN and HALTED. Reset enters RUN.

**Per-edge priority** (highest first):
1. `!i_rst_n`: PC=0, `o_Instr`=NOP_INSTR, `o_PCNext`=0, `o_Valid`=0, state=RUN.
2. `!i_Enable`: every register holds.
3. `i_Stall`: PC, IF/ID and state hold. Redirects are ignored; ID re-asserts them after the stall.
4. HALTED: PC holds. IF/ID loads NOP_INSTR with `o_Valid`=0. Redirects are ignored. Only reset leaves HALTED.
5. RUN with `i_Jump`: PC=`i_JumpAddr`. IF/ID is flushed (NOP_INSTR, `o_Valid`=0, `o_PCNext`=0). Jump wins over a simultaneous `i_Branch`.
6. RUN with `i_Branch`: PC=`i_BranchAddr`, with the same flush.
7. RUN, sequential: IF/ID loads `o_Instr`=`i_Instr`, `o_PCNext`=PC+1, `o_Valid`=1.
   - If `i_Instr`==HALT_INSTR: PC holds (keeps pointing at the HALT word) and state goes to HALTED.
   - Otherwise: PC=PC+1.

**Halt rules**
- A HALT word is only acted on when it is latched without a flush. A redirect in the same cycle discards it and the state stays RUN.
- The HALT word itself is presented once in IF/ID with `o_Valid`=1.

**Arithmetic:** PC+1 is modulo 2^ADDR_LENGTH. PC=all-ones wraps to 0, and `o_PCNext`=0 in that case.

**Outputs:** `o_Addr` is the PC register directly (no combinational path from inputs). `o_Halted` is 1 exactly when the state is HALTED.

## Timing

- **Fetch latency:** PC=A in cycle n. ROM word at A is visible in `o_Instr` after edge n+1.
- **Redirect:** asserted in cycle n.
  - Edge n+1: PC=target, IF/ID=bubble.
  - Edge n+2: target instruction in IF/ID.
  - Exactly one bubble per redirect.
- **Stall:** held for k cycles, freezes the front end for exactly k edges. Sequencing resumes on the first edge with `i_Stall`=0.
- **Enable low:** equivalent to a stall, and also freezes the state machine and the HALTED bubble insertion.
- **Reset mid-operation:** takes effect on the next edge regardless of stall, enable or state. `o_Addr`=0 the following cycle.
- **HALT at address H, fetched cycle n:**
  - Edge n+1: `o_Instr`=HALT_INSTR, `o_Halted`=1, `o_Addr` stays H.
  - Edge n+2 onward: `o_Valid`=0.

## Test plan

1. **Reset and sequential fetch.** ROM holds words 0..5; assert `i_rst_n`=0 for 2 cycles, then release. Required: all outputs at reset values; `o_Addr` goes 0,1,2,3; `o_Instr` trails by one cycle; `o_PCNext`=`o_Addr` of the fetch+1; `o_Valid`=1 from the first fetch.
2. **Stall.** At PC=3, hold `i_Stall`=1 for 3 cycles with `i_Branch`=1, `i_BranchAddr`=7 during the stall. Required: PC and IF/ID frozen at 3 and instr[2]; no redirect taken; PC=4 on the first unstalled edge.
3. **Branch flush.** At PC=4, pulse `i_Branch`=1 with `i_BranchAddr`=1 for one cycle. Required: next `o_Addr`=1 and IF/ID=NOP with `o_Valid`=0; the following cycle `o_Instr`=instr[1].
4. **Jump vs branch.** Assert `i_Jump` (addr 5) and `i_Branch` (addr 2) together. Required: PC=5 and one bubble.
5. **Halt.** Place HALT_INSTR at address 5 and run.
   - Required: `o_Instr`=32'hFFFFFFFF with `o_Valid`=1, `o_Halted`=1, `o_Addr` stuck at 5, then `o_Valid`=0 forever.
   - A redirect pulse while halted has no effect; reset returns `o_Addr` to 0 in RUN.
   - A separate run with a branch issued in the cycle HALT is fetched must not halt.
6. **Enable and wrap.** Hold `i_Enable`=0 for 4 cycles mid-run; required: no state change. Jump to 32'hFFFFFFFF; required: `o_PCNext`=0 and next PC=0.
